apb_master_bridge: RTL and testbench

- Single-outstanding APB initiator that converts a simple req/gnt core-side request port into APB SETUP/ACCESS transfers.
- Drives peripheral slaves such as the timer and other 4KB APB slaves; sits between the core/debug interconnect and the APB peripheral fabric.
- Handles PREADY wait states and returns read data, PSLVERR, and a bus-timeout error to the requester.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_bridge.sv | 148 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
// Imported by the bridge and by anything that decodes its state.
package apb_pkg;

    localparam int APB_DATA_WIDTH      = 32;
    localparam int APB_DEFAULT_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding req/gnt to APB initiator.
// Handles PREADY wait states, PSLVERR and a wait-state timeout abort.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    apb_state_e                state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_d;
    logic                      pwrite_d;
    logic                      psel_d;
    logic                      penable_d;
    logic                      rvalid_d;
    logic [APB_DATA_WIDTH-1:0] rdata_d;
    logic                      err_d;
    logic                      tmo_d;
    logic                      done;
    logic                      tmo_hit;

    assign gnt_o = req_i && (state_q == IDLE);
    assign done  = (state_q == ACCESS) && PSEL && PENABLE && PREADY;

    // Wait-state watchdog; absent entirely when TIMEOUT_CYCLES is 0.
    if (TIMEOUT_CYCLES != 0) begin : g_tmo
        localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
        logic [CW-1:0] cnt_q;

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                cnt_q <= '0;
            end else if (gnt_o) begin
                cnt_q <= '0;
            end else if ((state_q == ACCESS) && !PREADY && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        assign tmo_hit = (state_q == ACCESS) && !PREADY && (cnt_q == LIMIT);
    end else begin : g_no_tmo
        assign tmo_hit = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = PADDR;
        pwdata_d  = PWDATA;
        pwrite_d  = PWRITE;
        psel_d    = PSEL;
        penable_d = PENABLE;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_o;
        err_d     = err_o;
        tmo_d     = timeout_o;
        unique case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (req_i) begin
                    paddr_d  = addr_i;
                    pwrite_d = we_i;
                    pwdata_d = we_i ? wdata_i : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A same-cycle PREADY beats the watchdog.
                if (done) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = PWRITE ? '0 : PRDATA;
                    err_d     = PSLVERR;
                    tmo_d     = 1'b0;
                    state_d   = IDLE;
                end else if (tmo_hit) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    tmo_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            PWRITE    <= pwrite_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            rvalid_o  <= rvalid_d;
            rdata_o   <= rdata_d;
            err_o     <= err_d;
            timeout_o <= tmo_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a default-timeout instance
// plus a TIMEOUT_CYCLES=4 instance, both driven from one initial block.
module tb_apb_master_bridge;

    logic        HCLK = 1'b0;
    logic        HRESETn;

    logic        req, we, gnt, rvalid, err, tmo, pwrite, psel, penable;
    logic        pready, pslverr;
    logic [11:0] addr, paddr;
    logic [31:0] wdata, rdata, pwdata, prdata;

    logic        t_req, t_we, t_gnt, t_rvalid, t_err, t_tmo;
    logic        t_pwrite, t_psel, t_penable, t_pready, t_pslverr;
    logic [11:0] t_addr, t_paddr;
    logic [31:0] t_wdata, t_rdata, t_pwdata, t_prdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [logic [11:0]];

    always #5 HCLK = ~HCLK;

    apb_master_bridge dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .err_o(err), .timeout_o(tmo),
        .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
        .PSEL(psel), .PENABLE(penable),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_master_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_i(t_req), .addr_i(t_addr), .we_i(t_we), .wdata_i(t_wdata),
        .gnt_o(t_gnt), .rvalid_o(t_rvalid), .rdata_o(t_rdata),
        .err_o(t_err), .timeout_o(t_tmo),
        .PADDR(t_paddr), .PWDATA(t_pwdata), .PWRITE(t_pwrite),
        .PSEL(t_psel), .PENABLE(t_penable),
        .PRDATA(t_prdata), .PREADY(t_pready), .PSLVERR(t_pslverr)
    );

    // Drives one transfer on the main instance and reports what it saw.
    // The completing ACCESS cycle is the (waits+1)th one, so rvalid is
    // observed 3+waits cycles after the grant cycle.
    task automatic run_xfer(
        input  logic [11:0] a, input logic w, input logic [31:0] wd,
        input  int waits, input logic se, input logic [31:0] prd,
        output logic g, output logic [11:0] pa, output logic pw,
        output logic [31:0] pwd, output logic ph_ok, output logic rv,
        output logic [31:0] rd, output logic er, output logic to_,
        output logic ps_after, output logic rv_next);
        @(negedge HCLK);
        req = 1'b1; addr = a; we = w; wdata = wd; pready = 1'b0;
        #1 g = gnt;
        @(negedge HCLK);
        pa = paddr; pw = pwrite; pwd = pwdata;
        ph_ok = psel && !penable && !rvalid;
        // Junk on the requester port and slave inputs must be ignored.
        req = 1'b1; addr = 12'($urandom); we = 1'($urandom);
        wdata = $urandom; pready = 1'($urandom); pslverr = 1'($urandom);
        #1 ph_ok &= !gnt;
        for (int i = 0; i <= waits; i++) begin
            @(negedge HCLK);
            ph_ok &= psel && penable && !gnt && !rvalid;
            ph_ok &= (paddr == pa) && (pwrite == pw) && (pwdata == pwd);
            if (i == waits) begin
                pready = 1'b1; prdata = prd; pslverr = se; req = 1'b0;
            end else begin
                pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
            end
        end
        @(negedge HCLK);
        pready = 1'b0; pslverr = 1'b0;
        rv = rvalid; rd = rdata; er = err; to_ = tmo;
        ps_after = psel | penable;
        @(negedge HCLK);
        rv_next = rvalid;
    endtask

    task automatic test_reset();
        logic [83:0] v;
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        v = {psel, penable, pwrite, paddr, pwdata, rvalid, rdata, err, tmo};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_main: got %h want 0", v);
        end
        v = {t_psel, t_penable, t_pwrite, t_paddr, t_pwdata,
             t_rvalid, t_rdata, t_err, t_tmo};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_to: got %h want 0", v);
        end
        n_cmp++;
        if (gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_gnt_noreq: got %b want 0", gnt);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_timer_write();
        logic g, pw, ok, rv, er, to_, pa_, rvn;
        logic [11:0] pa;
        logic [31:0] pwd, rd;
        run_xfer(12'h008, 1'b1, 32'h0000_0010, 0, 1'b0, $urandom,
                 g, pa, pw, pwd, ok, rv, rd, er, to_, pa_, rvn);
        mem[12'h008] = 32'h0000_0010;
        n_cmp++;
        if (g !== 1'b1) begin
            n_bad++; $display("FAIL wr_gnt: got %b want 1", g);
        end
        n_cmp++;
        if ({pa, pw, pwd} !== {12'h008, 1'b1, 32'h10}) begin
            n_bad++;
            $display("FAIL wr_apb: got %h/%b/%h want 008/1/00000010",
                     pa, pw, pwd);
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++; $display("FAIL wr_phases: got %b want 1", ok);
        end
        n_cmp++;
        if ({rv, er, to_, rd, pa_, rvn} !== {3'b100, 32'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL wr_resp: got rv%b er%b to%b rd%h ps%b nx%b want rv1 er0 to0 rd0 ps0 nx0",
                     rv, er, to_, rd, pa_, rvn);
        end
    endtask

    task automatic test_timer_read();
        logic g, pw, ok, rv, er, to_, pa_, rvn;
        logic [11:0] pa;
        logic [31:0] pwd, rd;
        run_xfer(12'h008, 1'b0, $urandom, 0, 1'b0, mem[12'h008],
                 g, pa, pw, pwd, ok, rv, rd, er, to_, pa_, rvn);
        n_cmp++;
        if ({g, pa, pw, pwd, ok} !== {1'b1, 12'h008, 1'b0, 32'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL rd_req: got g%b %h %b %h ok%b want g1 008 0 0 ok1",
                     g, pa, pw, pwd, ok);
        end
        n_cmp++;
        if ({rv, er, to_, rd, rvn} !== {3'b100, 32'h10, 1'b0}) begin
            n_bad++;
            $display("FAIL rd_resp: got rv%b er%b to%b rd%h nx%b want rv1 er0 to0 rd00000010 nx0",
                     rv, er, to_, rd, rvn);
        end
    endtask

    task automatic test_wait_states();
        logic g, pw, ok, rv, er, to_, pa_, rvn;
        logic [11:0] pa, a;
        logic [31:0] pwd, rd;
        a = 12'($urandom);
        run_xfer(a, 1'b0, $urandom, 5, 1'b0, 32'hDEAD_BEEF,
                 g, pa, pw, pwd, ok, rv, rd, er, to_, pa_, rvn);
        n_cmp++;
        if ({g, pa, pw, ok} !== {1'b1, a, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL ws_stable: got g%b %h %b ok%b want g1 %h 0 ok1",
                     g, pa, pw, ok, a);
        end
        n_cmp++;
        if ({rv, er, to_, rd} !== {3'b100, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL ws_resp: got rv%b er%b to%b rd%h want rv1 er0 to0 rddeadbeef",
                     rv, er, to_, rd);
        end
    endtask

    task automatic test_slverr();
        logic g, pw, ok, rv, er, to_, pa_, rvn;
        logic [11:0] pa;
        logic [31:0] pwd, rd, prd;
        prd = $urandom;
        run_xfer(12'($urandom), 1'b0, 32'h0, 1, 1'b1, prd,
                 g, pa, pw, pwd, ok, rv, rd, er, to_, pa_, rvn);
        n_cmp++;
        if ({rv, er, to_, rd, ok} !== {3'b110, prd, 1'b1}) begin
            n_bad++;
            $display("FAIL slverr: got rv%b er%b to%b rd%h ok%b want rv1 er1 to0 rd%h ok1",
                     rv, er, to_, rd, ok, prd);
        end
    endtask

    task automatic test_random();
        logic g, pw, ok, rv, er, to_, pa_, rvn, w, se;
        logic [11:0] pa, a;
        logic [31:0] pwd, rd, wd, prd;
        logic [83:0] act, exp;
        int waits;
        for (int n = 0; n < 24; n++) begin
            a = {7'($urandom_range(0, 3)), 5'($urandom)};
            w = 1'($urandom);
            wd = $urandom;
            waits = $urandom_range(0, 3);
            se = ($urandom_range(0, 7) == 0);
            prd = mem.exists(a) ? mem[a] : 32'h0;
            run_xfer(a, w, wd, waits, se, prd,
                     g, pa, pw, pwd, ok, rv, rd, er, to_, pa_, rvn);
            if (w && !se) mem[a] = wd;
            act = {g, pa, pw, pwd, ok, rv, rd, er, to_, pa_, rvn};
            exp = {1'b1, a, w, (w ? wd : 32'h0), 1'b1, 1'b1,
                   (w ? 32'h0 : prd), se, 3'b000};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h want %h", n, act, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a1, a2;
        logic [31:0] d1, r2;
        a1 = 12'($urandom); a2 = 12'($urandom);
        d1 = $urandom; r2 = $urandom;
        @(negedge HCLK);
        req = 1'b1; addr = a1; we = 1'b1; wdata = d1;
        #1;
        n_cmp++;
        if (gnt !== 1'b1) begin
            n_bad++; $display("FAIL b2b_gnt1: got %b want 1", gnt);
        end
        @(negedge HCLK);
        addr = a2; we = 1'b0; wdata = $urandom;
        @(negedge HCLK);
        pready = 1'b1; pslverr = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 1'b0) begin
            n_bad++; $display("FAIL b2b_nogrant_access: got %b want 0", gnt);
        end
        @(negedge HCLK);
        pready = 1'b0;
        n_cmp++;
        if ({rvalid, gnt, err, psel} !== 4'b1100) begin
            n_bad++;
            $display("FAIL b2b_overlap: got rv%b gnt%b er%b psel%b want rv1 gnt1 er0 psel0",
                     rvalid, gnt, err, psel);
        end
        @(negedge HCLK);
        req = 1'b0;
        n_cmp++;
        if ({psel, penable, paddr, pwrite, pwdata} !== {2'b10, a2, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL b2b_setup2: got %b%b %h %b %h want 10 %h 0 0",
                     psel, penable, paddr, pwrite, pwdata, a2);
        end
        @(negedge HCLK);
        pready = 1'b1; prdata = r2;
        @(negedge HCLK);
        pready = 1'b0;
        n_cmp++;
        if ({rvalid, rdata, err} !== {1'b1, r2, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_resp2: got rv%b rd%h er%b want rv1 rd%h er0",
                     rvalid, rdata, err, r2);
        end
        @(negedge HCLK);
    endtask

    task automatic test_timeout(input logic race);
        logic [31:0] y;
        logic        se;
        y = $urandom;
        se = 1'($urandom);
        @(negedge HCLK);
        t_req = 1'b1; t_addr = 12'($urandom); t_we = 1'b0;
        #1;
        n_cmp++;
        if (t_gnt !== 1'b1) begin
            n_bad++; $display("FAIL to_gnt: got %b want 1", t_gnt);
        end
        @(negedge HCLK);
        t_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            n_cmp++;
            if ({t_psel, t_penable, t_rvalid} !== 3'b110) begin
                n_bad++;
                $display("FAIL to_wait[%0d]: got %b%b%b want 110",
                         i, t_psel, t_penable, t_rvalid);
            end
            t_pready = race && (i == 3);
            t_prdata = y; t_pslverr = se;
        end
        @(negedge HCLK);
        t_pready = 1'b0; t_pslverr = 1'b0;
        if (race) begin
            n_cmp++;
            if ({t_rvalid, t_err, t_tmo, t_rdata} !== {1'b1, se, 1'b0, y}) begin
                n_bad++;
                $display("FAIL to_race: got rv%b er%b to%b rd%h want rv1 er%b to0 rd%h",
                         t_rvalid, t_err, t_tmo, t_rdata, se, y);
            end
        end else begin
            n_cmp++;
            if ({t_rvalid, t_err, t_tmo, t_rdata, t_psel} !== {3'b111, 32'h0, 1'b0}) begin
                n_bad++;
                $display("FAIL to_abort: got rv%b er%b to%b rd%h psel%b want rv1 er1 to1 rd0 psel0",
                         t_rvalid, t_err, t_tmo, t_rdata, t_psel);
            end
            t_req = 1'b1; t_addr = 12'h010; t_we = 1'b0;
            #1;
            n_cmp++;
            if (t_gnt !== 1'b1) begin
                n_bad++; $display("FAIL to_next_gnt: got %b want 1", t_gnt);
            end
            @(negedge HCLK);
            t_req = 1'b0;
            @(negedge HCLK);
            t_pready = 1'b1; t_prdata = y; t_pslverr = 1'b0;
            @(negedge HCLK);
            t_pready = 1'b0;
            n_cmp++;
            if ({t_rvalid, t_err, t_tmo, t_rdata} !== {3'b100, y}) begin
                n_bad++;
                $display("FAIL to_after: got rv%b er%b to%b rd%h want rv1 er0 to0 rd%h",
                         t_rvalid, t_err, t_tmo, t_rdata, y);
            end
        end
        @(negedge HCLK);
    endtask

    task automatic test_reset_mid();
        logic g, pw, ok, rv, er, to_, pa_, rvn, seen;
        logic [11:0] pa;
        logic [31:0] pwd, rd, prd;
        @(negedge HCLK);
        req = 1'b1; addr = 12'h020; we = 1'b0;
        @(negedge HCLK);
        req = 1'b0;
        @(negedge HCLK);
        pready = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        n_cmp++;
        if ({psel, penable} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_mid_async: got %b%b want 00", psel, penable);
        end
        seen = 1'b0;
        repeat (2) begin
            @(negedge HCLK);
            seen |= rvalid;
        end
        HRESETn = 1'b1;
        repeat (2) begin
            @(negedge HCLK);
            seen |= rvalid | psel;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_noresp: got %b want 0", seen);
        end
        prd = $urandom;
        run_xfer(12'h004, 1'b0, 32'h0, 0, 1'b0, prd,
                 g, pa, pw, pwd, ok, rv, rd, er, to_, pa_, rvn);
        n_cmp++;
        if ({g, ok, rv, rd, er, to_} !== {3'b111, prd, 2'b00}) begin
            n_bad++;
            $display("FAIL rst_mid_recover: got g%b ok%b rv%b rd%h er%b to%b want g1 ok1 rv1 rd%h er0 to0",
                     g, ok, rv, rd, er, to_, prd);
        end
    endtask

    initial begin
        req = 1'b0; addr = '0; we = 1'b0; wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        t_req = 1'b0; t_addr = '0; t_we = 1'b0; t_wdata = '0;
        t_pready = 1'b0; t_pslverr = 1'b0; t_prdata = '0;
        test_reset();
        test_timer_write();
        test_timer_read();
        test_wait_states();
        test_slverr();
        test_random();
        test_back_to_back();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
